// File: rtl/game_sequencer.sv
// game_sequencer: debounces Flappy buttons into pulses, sequences idle/run/lose,
// generates pipe/physics/flash tick enables and tracks the high score.
module game_sequencer #(
  parameter int DEB_CYCLES = 1000000,
  parameter int PIPE_DIV = 524288,
  parameter int PHYS_DIV = 1048576,
  parameter int FLASH_DIV = 4194304,
  parameter int SCORE_W = 4
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               BtnU,
  input  logic               BtnC,
  input  logic               BtnD,
  input  logic               Lose,
  input  logic [SCORE_W-1:0] Score,
  output logic               Start,
  output logic               Ack,
  output logic               Jump,
  output logic               Pipe_Tick,
  output logic               Phys_Tick,
  output logic               Flash_Blue,
  output logic [SCORE_W-1:0] High_Score,
  output logic               New_High,
  output logic               Q_Idle,
  output logic               Q_Run,
  output logic               Q_Lose
);
  localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = PIPE_DIV > 1 ? $clog2(PIPE_DIV) : 1;
  localparam int HW = PHYS_DIV > 1 ? $clog2(PHYS_DIV) : 1;
  localparam int FW = FLASH_DIV > 1 ? $clog2(FLASH_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, LOSE} state_t;
  state_t state, state_n;
  logic [2:0] raw, s1, s2, deb, deb_d, press;
  logic [2:0][DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic [HW-1:0] hcnt;
  logic [FW-1:0] fcnt;
  logic start_n, ack_n, jump_n, run_go, lose_go;
  assign raw = {BtnD, BtnC, BtnU};
  assign press = deb & ~deb_d;
  // press bit order: 0 start, 1 jump, 2 ack
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_d <= '0;
      dcnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        dcnt[i] <= (s2[i] == deb[i] || dcnt[i] == DW'(DEB_CYCLES - 1)) ? '0 : dcnt[i] + 1'b1;
        if (s2[i] != deb[i] && dcnt[i] == DW'(DEB_CYCLES - 1)) deb[i] <= ~deb[i];
      end
    end
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      Start <= 1'b0;
      Ack <= 1'b0;
      Jump <= 1'b0;
    end else begin
      state <= state_n;
      Start <= start_n;
      Ack <= ack_n;
      Jump <= jump_n;
    end
  always_comb begin
    state_n = (state == IDLE && press[0]) ? RUN :
              (state == RUN && Lose) ? LOSE :
              (state == LOSE && press[2]) ? IDLE : state;
    start_n = state == IDLE && press[0];
    jump_n = state == RUN && !Lose && press[1];
    ack_n = state == LOSE && press[2];
  end
  always_comb begin
    Q_Idle = state == IDLE;
    Q_Run = state == RUN;
    Q_Lose = state == LOSE;
  end
  // counters only advance while staying in a state, so entry always restarts them at 0
  assign run_go = state == RUN && state_n == RUN;
  assign lose_go = state == LOSE && state_n == LOSE;
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      pcnt <= '0;
      hcnt <= '0;
      fcnt <= '0;
      Pipe_Tick <= 1'b0;
      Phys_Tick <= 1'b0;
      Flash_Blue <= 1'b0;
    end else begin
      pcnt <= (run_go && pcnt != PW'(PIPE_DIV - 1)) ? pcnt + 1'b1 : '0;
      hcnt <= (run_go && hcnt != HW'(PHYS_DIV - 1)) ? hcnt + 1'b1 : '0;
      fcnt <= (lose_go && fcnt != FW'(FLASH_DIV - 1)) ? fcnt + 1'b1 : '0;
      Pipe_Tick <= run_go && pcnt == PW'(PIPE_DIV - 1);
      Phys_Tick <= run_go && hcnt == HW'(PHYS_DIV - 1);
      Flash_Blue <= lose_go && (Flash_Blue ^ (fcnt == FW'(FLASH_DIV - 1)));
    end
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      High_Score <= '0;
      New_High <= 1'b0;
    end else if (start_n) begin
      New_High <= 1'b0;
    end else if (state == RUN && Lose && Score > High_Score) begin
      High_Score <= Score;
      New_High <= 1'b1;
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed stimulus with a cycle-level behavioural model and literal checks.
module tb_game_sequencer;
  localparam int DEB = 4, PD = 8, HD = 16, FD = 4, SW = 4;
  logic Clk = 0, reset = 0, BtnU = 0, BtnC = 0, BtnD = 0, Lose = 0;
  logic [SW-1:0] Score = '0;
  logic Start, Ack, Jump, Pipe_Tick, Phys_Tick, Flash_Blue, New_High, Q_Idle, Q_Run, Q_Lose;
  logic [SW-1:0] High_Score;
  int total = 0, bad = 0, n_start = 0, n_jump = 0, n_ack = 0;
  int ms = 0, rc = 0, lc = 0;
  int e_hs = 0;
  bit e_nh, e_start, e_ack, e_jump, e_pt, e_ht, e_fb;
  bit [2:0] mdeb, pend;
  bit h[3][16];

  game_sequencer #(.DEB_CYCLES(DEB), .PIPE_DIV(PD), .PHYS_DIV(HD), .FLASH_DIV(FD), .SCORE_W(SW)) dut (
    .Clk(Clk), .reset(reset), .BtnU(BtnU), .BtnC(BtnC), .BtnD(BtnD), .Lose(Lose), .Score(Score),
    .Start(Start), .Ack(Ack), .Jump(Jump), .Pipe_Tick(Pipe_Tick), .Phys_Tick(Phys_Tick),
    .Flash_Blue(Flash_Blue), .High_Score(High_Score), .New_High(New_High),
    .Q_Idle(Q_Idle), .Q_Run(Q_Run), .Q_Lose(Q_Lose));

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // model: a button is accepted once its level, seen two samples late, has held for DEB samples
  initial begin
    bit rw[3];
    bit all_diff;
    forever begin
      @(posedge Clk or negedge reset);
      if (!reset) begin
        ms = 0; rc = 0; lc = 0; e_hs = 0; e_nh = 0;
        e_start = 0; e_ack = 0; e_jump = 0; e_pt = 0; e_ht = 0; e_fb = 0;
        mdeb = '0; pend = '0;
        for (int b = 0; b < 3; b++) for (int i = 0; i < 16; i++) h[b][i] = 0;
      end else begin
        rw[0] = BtnU; rw[1] = BtnC; rw[2] = BtnD;
        e_start = 0; e_ack = 0; e_jump = 0;
        case (ms)
          0: if (pend[0]) begin ms = 1; rc = 0; e_start = 1; e_nh = 0; end
          1: if (Lose) begin
               ms = 2; lc = 0;
               if (int'(Score) > e_hs) begin e_hs = int'(Score); e_nh = 1; end
             end else begin
               rc++; e_jump = pend[1];
             end
          default: if (pend[2]) begin ms = 0; e_ack = 1; end else lc++;
        endcase
        e_pt = ms == 1 && rc > 0 && rc % PD == 0;
        e_ht = ms == 1 && rc > 0 && rc % HD == 0;
        e_fb = ms == 2 && (lc / FD) % 2 == 1;
        for (int b = 0; b < 3; b++) begin
          for (int i = 15; i > 0; i--) h[b][i] = h[b][i-1];
          h[b][0] = rw[b];
          all_diff = 1;
          for (int j = 0; j < DEB; j++) if (h[b][2+j] == mdeb[b]) all_diff = 0;
          pend[b] = all_diff && !mdeb[b];
          if (all_diff) mdeb[b] = !mdeb[b];
        end
      end
    end
  end

  always @(negedge Clk) begin
    chk("start", Start, e_start);
    chk("ack", Ack, e_ack);
    chk("jump", Jump, e_jump);
    chk("pipe_tick", Pipe_Tick, e_pt);
    chk("phys_tick", Phys_Tick, e_ht);
    chk("flash_blue", Flash_Blue, e_fb);
    chk("high_score", High_Score, e_hs);
    chk("new_high", New_High, e_nh);
    chk("q_idle", Q_Idle, ms == 0);
    chk("q_run", Q_Run, ms == 1);
    chk("q_lose", Q_Lose, ms == 2);
    n_start += Start;
    n_jump += Jump;
    n_ack += Ack;
  end

  task automatic press(input int b);
    @(negedge Clk);
    if (b == 0) BtnU = 1; else if (b == 1) BtnC = 1; else BtnD = 1;
    repeat (10) @(negedge Clk);
    BtnU = 0; BtnC = 0; BtnD = 0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic lose_pulse(input int s);
    @(negedge Clk);
    Score = SW'(s);
    Lose = 1;
    @(negedge Clk);
    Lose = 0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_idle", Q_Idle, 1);
    chk("rst_run", Q_Run, 0);
    chk("rst_hs", High_Score, 0);
    chk("rst_fb", Flash_Blue, 0);
    reset = 1;
    repeat (2) @(negedge Clk);
    BtnU = 1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge Clk); #1;
      chk("start_latency", Start, i == 7);
    end
    chk("start_q_run", Q_Run, 1);
    for (int j = 1; j <= 16; j++) begin
      @(posedge Clk); #1;
      if (j == 1) chk("start_once", Start, 0);
      chk("pipe_tick_lit", Pipe_Tick, j == 8 || j == 16);
      chk("phys_tick_lit", Phys_Tick, j == 16);
    end
    @(negedge Clk);
    BtnU = 0;
    repeat (10) @(negedge Clk);
    for (int i = 0; i < 10; i++) begin
      BtnC = (i % 2 == 0);
      @(negedge Clk);
    end
    repeat (3) @(negedge Clk);
    chk("bounce_no_jump", n_jump, 0);
    BtnC = 1;
    repeat (50) @(negedge Clk);
    chk("held_one_jump", n_jump, 1);
    BtnC = 0;
    repeat (10) @(negedge Clk);
    Score = 5;
    BtnC = 1;
    repeat (6) @(negedge Clk);
    Lose = 1;
    @(posedge Clk); #1;
    chk("lose_state", Q_Lose, 1);
    chk("lose_no_jump", Jump, 0);
    chk("lose_hs5", High_Score, 5);
    chk("lose_nh", New_High, 1);
    for (int j = 1; j <= 12; j++) begin
      @(posedge Clk); #1;
      chk("flash_lit", Flash_Blue, (j / 4) % 2);
      chk("lose_no_tick", Pipe_Tick, 0);
    end
    chk("lose_jump_dropped", n_jump, 1);
    @(negedge Clk);
    Lose = 0;
    BtnC = 0;
    repeat (10) @(negedge Clk);
    press(2);
    chk("ack_count", n_ack, 1);
    chk("ack_idle", Q_Idle, 1);
    chk("ack_flash", Flash_Blue, 0);
    press(0);
    chk("game2_run", Q_Run, 1);
    lose_pulse(5);
    chk("equal_lose", Q_Lose, 1);
    chk("equal_hs", High_Score, 5);
    chk("equal_nh", New_High, 0);
    press(2);
    press(1);
    chk("idle_jump_ignored", n_jump, 1);
    chk("idle_stays", Q_Idle, 1);
    press(0);
    chk("game3_run", Q_Run, 1);
    press(0);
    press(2);
    chk("run_start_ignored", n_start, 3);
    chk("run_ack_ignored", n_ack, 2);
    chk("run_stays", Q_Run, 1);
    lose_pulse(7);
    chk("hs7", High_Score, 7);
    chk("hs7_nh", New_High, 1);
    repeat (3) @(negedge Clk);
    #2 reset = 0;
    #1;
    chk("arst_idle", Q_Idle, 1);
    chk("arst_lose", Q_Lose, 0);
    chk("arst_hs", High_Score, 0);
    chk("arst_nh", New_High, 0);
    chk("arst_fb", Flash_Blue, 0);
    chk("arst_ack", Ack, 0);
    repeat (2) @(negedge Clk);
    chk("arst_no_ack", n_ack, 2);
    reset = 1;
    press(0);
    chk("after_rst_run", Q_Run, 1);
    chk("after_rst_start", n_start, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
